// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start bit, DATA_BITS data bits LSB first, optional parity, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 frame_done,
    output logic [3:0]           bit_idx
);

    localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BIT_LAST = 4'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_out_q, tx_out_d;
    logic                 frame_done_q, frame_done_d;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            baud_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            tx_out_q     <= 1'b1;
            frame_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            baud_cnt_q   <= baud_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            tx_out_q     <= tx_out_d;
            frame_done_q <= frame_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Next-state logic; tx_out is derived from the next state so the line changes with the state.
    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        frame_done_d = 1'b0;
        tx_out_d     = 1'b1;
        bit_end      = (baud_cnt_q == CNT_LAST);
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                if (tx_valid) begin
                    shift_d = tx_data;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == BIT_LAST) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                baud_cnt_d = '0;
                bit_idx_d  = '0;
            end
        endcase

        if (state_q != IDLE) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_out_d = parity_d;
`endif
            default: tx_out_d = 1'b1;
        endcase
    end

    assign tx_ready   = (state_q == IDLE);
    assign tx_busy    = (state_q != IDLE);
    assign tx_out     = tx_out_q;
    assign frame_done = frame_done_q;
    assign bit_idx    = bit_idx_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (4 clocks/bit x 8 bits, 1 clock/bit x 5 bits) checked
// against a frame-level model through accept-time scoreboards and per-cycle line monitors.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

    localparam int CPB_A = 4;
    localparam int DB_A  = 8;
    localparam int CPB_B = 1;
    localparam int DB_B  = 5;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic            clk  = 1'b0;
    logic            nrst = 1'b1;
    logic            a_valid = 1'b0;
    logic [DB_A-1:0] a_data  = '0;
    logic            a_ready, a_out, a_busy, a_done;
    logic [3:0]      a_idx;
    logic            b_valid = 1'b0;
    logic [DB_B-1:0] b_data  = '0;
    logic            b_ready, b_out, b_busy, b_done;
    logic [3:0]      b_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          acc_cyc;
    } frame_t;

    frame_t sb_a[$];
    frame_t sb_b[$];
    frame_t cur_a, cur_b;
    bit     in_a = 1'b0, in_b = 1'b0;
    int     pos_a = 0, pos_b = 0, bit_a = 0, bit_b = 0;

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(DB_A)) dut_a (
        .clk(clk), .nrst(nrst), .tx_valid(a_valid), .tx_data(a_data), .tx_ready(a_ready),
        .tx_out(a_out), .tx_busy(a_busy), .frame_done(a_done), .bit_idx(a_idx)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(DB_B)) dut_b (
        .clk(clk), .nrst(nrst), .tx_valid(b_valid), .tx_data(b_data), .tx_ready(b_ready),
        .tx_out(b_out), .tx_busy(b_busy), .frame_done(b_done), .bit_idx(b_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    // Serial line image of one frame: start 0, data LSB first, optional even parity, stop 1.
    function automatic frame_t modelFrame(input logic [7:0] data, input int nd, input int acc);
        frame_t f;
        logic   p;
        int     k;
        f.bits    = '0;
        p         = 1'b0;
        for (int i = 0; i < nd; i++) begin
            f.bits[1+i] = data[i];
            p           = p ^ data[i];
        end
        k = 1 + nd;
        if (PAR != 0) begin
            f.bits[k] = p;
            k++;
        end
        f.bits[k] = 1'b1;
        f.nbits   = k + 1;
        f.acc_cyc = acc;
        return f;
    endfunction

    initial forever begin
        @(negedge clk);
        if (nrst && a_valid && a_ready) sb_a.push_back(modelFrame(a_data, DB_A, cyc));
        if (nrst && b_valid && b_ready) sb_b.push_back(modelFrame(8'(b_data), DB_B, cyc));
    end

    initial forever begin
        @(negedge clk);
        if (!nrst) begin
            checkOutput("a_reset_state", {a_done, a_ready, a_busy, a_out, a_idx}, {4'b0101, 4'd0});
            in_a = 1'b0;
            sb_a.delete();
        end else begin
            if (!in_a && a_out == 1'b0) begin
                checkOutput("a_start_expected", sb_a.size() > 0, 1);
                if (sb_a.size() > 0) begin
                    cur_a = sb_a.pop_front();
                    checkOutput("a_start_latency", cyc - cur_a.acc_cyc, 1);
                    in_a  = 1'b1;
                    pos_a = 0;
                end
            end
            if (in_a) begin
                if (pos_a < cur_a.nbits * CPB_A) begin
                    bit_a = pos_a / CPB_A;
                    checkOutput("a_line_bit", a_out, cur_a.bits[bit_a]);
                    checkOutput("a_busy_ready_done", {a_busy, a_ready, a_done}, 3'b100);
                    checkOutput("a_bit_idx", a_idx, (bit_a >= 1 && bit_a <= DB_A) ? bit_a - 1 : 0);
                    pos_a++;
                end else begin
                    checkOutput("a_frame_done", {a_done, a_ready, a_busy, a_out, a_idx}, {4'b1101, 4'd0});
                    in_a = 1'b0;
                end
            end else begin
                checkOutput("a_idle_state", {a_done, a_ready, a_busy, a_out, a_idx}, {4'b0101, 4'd0});
                if (sb_a.size() > 0 && cyc - sb_a[0].acc_cyc > 1) begin
                    checkOutput("a_start_timeout", a_out, 0);
                    void'(sb_a.pop_front());
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!nrst) begin
            checkOutput("b_reset_state", {b_done, b_ready, b_busy, b_out, b_idx}, {4'b0101, 4'd0});
            in_b = 1'b0;
            sb_b.delete();
        end else begin
            if (!in_b && b_out == 1'b0) begin
                checkOutput("b_start_expected", sb_b.size() > 0, 1);
                if (sb_b.size() > 0) begin
                    cur_b = sb_b.pop_front();
                    checkOutput("b_start_latency", cyc - cur_b.acc_cyc, 1);
                    in_b  = 1'b1;
                    pos_b = 0;
                end
            end
            if (in_b) begin
                if (pos_b < cur_b.nbits * CPB_B) begin
                    bit_b = pos_b / CPB_B;
                    checkOutput("b_line_bit", b_out, cur_b.bits[bit_b]);
                    checkOutput("b_busy_ready_done", {b_busy, b_ready, b_done}, 3'b100);
                    checkOutput("b_bit_idx", b_idx, (bit_b >= 1 && bit_b <= DB_B) ? bit_b - 1 : 0);
                    pos_b++;
                end else begin
                    checkOutput("b_frame_done", {b_done, b_ready, b_busy, b_out, b_idx}, {4'b1101, 4'd0});
                    in_b = 1'b0;
                end
            end else begin
                checkOutput("b_idle_state", {b_done, b_ready, b_busy, b_out, b_idx}, {4'b0101, 4'd0});
                if (sb_b.size() > 0 && cyc - sb_b[0].acc_cyc > 1) begin
                    checkOutput("b_start_timeout", b_out, 0);
                    void'(sb_b.pop_front());
                end
            end
        end
    end

    // mode 0: quiet while busy, 1: random valid and data while busy, 2: valid held with random data
    task automatic applyStimulus(input logic [7:0] data, input int mode);
        int k;
        a_valid = 1'b1;
        a_data  = data;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (a_ready) break;
            @(posedge clk); #1;
        end
        checkOutput("a_accept_ready", a_ready, 1);
        @(posedge clk); #1;
        for (k = 0; k < 400 && !a_ready; k++) begin
            if (mode == 1) begin
                a_valid = 1'($urandom);
                a_data  = 8'($urandom);
            end else if (mode == 2) begin
                a_valid = 1'b1;
                a_data  = 8'($urandom);
            end else begin
                a_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        checkOutput("a_return_idle", a_ready, 1);
        a_valid = 1'b0;
    endtask

    task automatic sendB(input logic [4:0] data, input bit hold);
        int k;
        b_valid = 1'b1;
        b_data  = data;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (b_ready) break;
            @(posedge clk); #1;
        end
        checkOutput("b_accept_ready", b_ready, 1);
        @(posedge clk); #1;
        for (k = 0; k < 100 && !b_ready; k++) begin
            b_valid = hold;
            b_data  = 5'($urandom);
            @(posedge clk); #1;
        end
        checkOutput("b_return_idle", b_ready, 1);
        b_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Abort a frame with reset during data bit 3 (line cycles 16..19 after the accept edge).
    task automatic midFrameReset(input logic [7:0] data);
        a_valid = 1'b1;
        a_data  = data;
        @(negedge clk);
        checkOutput("pre_abort_ready", a_ready, 1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        checkOutput("pre_abort_idx", a_idx, 3);
        nrst = 1'b0;
        #1;
        checkOutput("abort_tx_out", a_out, 1);
        checkOutput("abort_busy", a_busy, 0);
        checkOutput("abort_idx", a_idx, 0);
        repeat (3) @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    initial begin
        #1 nrst = 1'b0;
        repeat (5) @(posedge clk);
        #1 nrst = 1'b1;
        idleCycles(20);

        applyStimulus(8'hA5, 0);
        idleCycles(3);
        applyStimulus(8'h00, 2);
        applyStimulus(8'hFF, 0);
        idleCycles(2);
        applyStimulus(8'h07, 1);
        idleCycles(2);

        midFrameReset(8'h0F);
        idleCycles(2);
        applyStimulus(8'h3C, 0);

        for (int i = 0; i < 25; i++) begin
            applyStimulus(8'($urandom), int'($urandom_range(0, 2)));
            idleCycles(int'($urandom_range(0, 3)));
        end

        sendB(5'h15, 1'b0);
        idleCycles(2);
        sendB(5'h00, 1'b1);
        sendB(5'h1F, 1'b0);
        for (int i = 0; i < 12; i++) begin
            sendB(5'($urandom), 1'($urandom));
            idleCycles(int'($urandom_range(0, 2)));
        end

        idleCycles(60);
        checkOutput("a_scoreboard_drained", sb_a.size(), 0);
        checkOutput("b_scoreboard_drained", sb_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
